// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter.
// Provides tag/data/address widths, zero constants, source encodings and the
// per-source queue payload structs.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_ID_W   = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ADDR_W-1:0]   addr_t;

    localparam rob_id_t ZERO_ROB  = '0;
    localparam data_t   ZERO_WORD = '0;
    localparam addr_t   ZERO_ADDR = '0;
    localparam logic    TRUE      = 1'b1;
    localparam logic    FALSE     = 1'b0;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LS  = 1'b1;

    typedef struct packed {
        rob_id_t rob_id;
        data_t   result;
        addr_t   target_pc;
        logic    jump_flag;
    } alu_entry_t;

    // Loads/stores never redirect, so the LS queue carries no pc/jump fields.
    typedef struct packed {
        rob_id_t rob_id;
        data_t   result;
    } ls_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small circular queue used as a per-producer skid buffer.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             global enable; when low all state holds
//   flush          empties the queue at the next edge (overrides en)
//   push/push_data write an entry (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   head_data      current head entry
//   empty/full     occupancy flags from registered state
module cdb_src_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(Depth));
    assign head_data = mem_q[head_q];

    assign do_push = en & ~flush & push & ~full;
    assign do_pop  = en & ~flush & pop & ~empty;

    // Depth is a power of two, so pointer increments wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PtrW'(1);
            if (do_pop)  head_d = head_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush || en) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two skid queues (ALU, load/store) feeding a
// round-robin scheduler that drives a registered broadcast bus.
// Ports:
//   clk, rst, rdy, rollback_flag   clock, sync reset, global enable, flush
//   alu_*                          ALU result handshake and payload
//   ls_*                           load/store result handshake and payload
//   cdb_*                          registered broadcast (valid pulse + fields)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback_flag,

    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [ADDR_W-1:0]   alu_target_pc,
    input  logic                alu_jump_flag,

    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic [ROB_ID_W-1:0] ls_rob_id,
    input  logic [DATA_W-1:0]   ls_result,

    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_result,
    output logic [ADDR_W-1:0]   cdb_target_pc,
    output logic                cdb_jump_flag,
    output logic                cdb_src
);

    alu_entry_t alu_in, alu_head;
    ls_entry_t  ls_in, ls_head;
    logic       alu_empty, alu_full, ls_empty, ls_full;
    logic       alu_push, ls_push;
    logic       grant_alu, grant_ls;
    logic       last_grant_q;

    logic                cdb_valid_q;
    logic [ROB_ID_W-1:0] cdb_rob_id_q;
    logic [DATA_W-1:0]   cdb_result_q;
    logic [ADDR_W-1:0]   cdb_target_pc_q;
    logic                cdb_jump_flag_q;
    logic                cdb_src_q;

    assign alu_ready = ~alu_full;
    assign ls_ready  = ~ls_full;

    assign alu_in = '{rob_id: alu_rob_id, result: alu_result,
                      target_pc: alu_target_pc, jump_flag: alu_jump_flag};
    assign ls_in  = '{rob_id: ls_rob_id, result: ls_result};

    // Tag 0 means "no entry": the handshake completes but nothing is stored.
    assign alu_push = alu_valid & (alu_rob_id != ZERO_ROB);
    assign ls_push  = ls_valid & (ls_rob_id != ZERO_ROB);

    // Grant looks only at start-of-cycle occupancy; ties go opposite last_grant.
    assign grant_alu = ~alu_empty & (ls_empty | (last_grant_q == CDB_SRC_LS));
    assign grant_ls  = ~ls_empty & (alu_empty | (last_grant_q == CDB_SRC_ALU));

    cdb_src_fifo #(
        .Width ($bits(alu_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush     (rollback_flag),
        .push      (alu_push),
        .push_data (alu_in),
        .pop       (grant_alu),
        .head_data (alu_head),
        .empty     (alu_empty),
        .full      (alu_full)
    );

    cdb_src_fifo #(
        .Width ($bits(ls_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_ls_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush     (rollback_flag),
        .push      (ls_push),
        .push_data (ls_in),
        .pop       (grant_ls),
        .head_data (ls_head),
        .empty     (ls_empty),
        .full      (ls_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q     <= FALSE;
            cdb_rob_id_q    <= ZERO_ROB;
            cdb_result_q    <= ZERO_WORD;
            cdb_target_pc_q <= ZERO_ADDR;
            cdb_jump_flag_q <= FALSE;
            cdb_src_q       <= CDB_SRC_ALU;
            last_grant_q    <= CDB_SRC_LS;
        end else if (rollback_flag) begin
            cdb_valid_q  <= FALSE;
            last_grant_q <= CDB_SRC_LS;
        end else if (rdy) begin
            if (grant_alu) begin
                cdb_valid_q     <= TRUE;
                cdb_rob_id_q    <= alu_head.rob_id;
                cdb_result_q    <= alu_head.result;
                cdb_target_pc_q <= alu_head.target_pc;
                cdb_jump_flag_q <= alu_head.jump_flag;
                cdb_src_q       <= CDB_SRC_ALU;
                last_grant_q    <= CDB_SRC_ALU;
            end else if (grant_ls) begin
                cdb_valid_q     <= TRUE;
                cdb_rob_id_q    <= ls_head.rob_id;
                cdb_result_q    <= ls_head.result;
                cdb_target_pc_q <= ZERO_ADDR;
                cdb_jump_flag_q <= FALSE;
                cdb_src_q       <= CDB_SRC_LS;
                last_grant_q    <= CDB_SRC_LS;
            end else begin
                // Data fields deliberately hold their last broadcast.
                cdb_valid_q <= FALSE;
            end
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_rob_id    = cdb_rob_id_q;
    assign cdb_result    = cdb_result_q;
    assign cdb_target_pc = cdb_target_pc_q;
    assign cdb_jump_flag = cdb_jump_flag_q;
    assign cdb_src       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback_flag;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rob_id;
    logic [31:0] alu_result;
    logic [31:0] alu_target_pc;
    logic        alu_jump_flag;
    logic        ls_valid;
    logic        ls_ready;
    logic [4:0]  ls_rob_id;
    logic [31:0] ls_result;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_result;
    logic [31:0] cdb_target_pc;
    logic        cdb_jump_flag;
    logic        cdb_src;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .rollback_flag (rollback_flag),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rob_id    (alu_rob_id),
        .alu_result    (alu_result),
        .alu_target_pc (alu_target_pc),
        .alu_jump_flag (alu_jump_flag),
        .ls_valid      (ls_valid),
        .ls_ready      (ls_ready),
        .ls_rob_id     (ls_rob_id),
        .ls_result     (ls_result),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_result    (cdb_result),
        .cdb_target_pc (cdb_target_pc),
        .cdb_jump_flag (cdb_jump_flag),
        .cdb_src       (cdb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]  rob;
        logic [31:0] result;
        logic [31:0] pc;
        logic        jump;
        logic        src;
    } bcast_t;

    // Reference model: each producer queue is a plain SV queue of entries.
    bcast_t aq[$];
    bcast_t lq[$];
    bcast_t exp_q[$];
    logic   m_last_ls;
    logic   m_valid;
    logic   edge_rst;
    logic   edge_en;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int     na, nl;
        bcast_t e;
        edge_rst = 1'b0;
        edge_en  = 1'b0;
        if (rst) begin
            aq.delete();
            lq.delete();
            m_last_ls = 1'b1;
            m_valid   = 1'b0;
            edge_rst  = 1'b1;
        end else if (rollback_flag) begin
            aq.delete();
            lq.delete();
            m_last_ls = 1'b1;
            m_valid   = 1'b0;
        end else if (rdy) begin
            edge_en = 1'b1;
            na = aq.size();
            nl = lq.size();
            m_valid = 1'b0;
            if (na > 0 && (nl == 0 || m_last_ls)) begin
                e = aq.pop_front();
                exp_q.push_back(e);
                m_last_ls = 1'b0;
                m_valid   = 1'b1;
            end else if (nl > 0) begin
                e = lq.pop_front();
                exp_q.push_back(e);
                m_last_ls = 1'b1;
                m_valid   = 1'b1;
            end
            // Acceptance uses occupancy before this cycle's pop.
            if (alu_valid && na < 2 && alu_rob_id != 5'd0)
                aq.push_back('{rob: alu_rob_id, result: alu_result, pc: alu_target_pc,
                               jump: alu_jump_flag, src: 1'b0});
            if (ls_valid && nl < 2 && ls_rob_id != 5'd0)
                lq.push_back('{rob: ls_rob_id, result: ls_result, pc: 32'd0,
                               jump: 1'b0, src: 1'b1});
        end
    endtask

    initial begin
        m_last_ls = 1'b1;
        m_valid   = 1'b0;
        edge_rst  = 1'b0;
        edge_en   = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a fresh broadcast.
    initial begin
        bcast_t last_seen;
        bcast_t e;
        last_seen = '0;
        forever begin
            @(negedge clk);
            if (edge_rst) last_seen = '0;
            if (edge_en && cdb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bcast", {59'd0, cdb_rob_id}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    last_seen = e;
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missed_bcast", {63'd0, cdb_valid}, 64'd1);
                last_seen = e;
            end
            chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_valid});
            chk("cdb_rob_id", {59'd0, cdb_rob_id}, {59'd0, last_seen.rob});
            chk("cdb_result", {32'd0, cdb_result}, {32'd0, last_seen.result});
            chk("cdb_target_pc", {32'd0, cdb_target_pc}, {32'd0, last_seen.pc});
            chk("cdb_jump_flag", {63'd0, cdb_jump_flag}, {63'd0, last_seen.jump});
            chk("cdb_src", {63'd0, cdb_src}, {63'd0, last_seen.src});
            chk("alu_ready", {63'd0, alu_ready}, {63'd0, (aq.size() < 2)});
            chk("ls_ready", {63'd0, ls_ready}, {63'd0, (lq.size() < 2)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid     = 1'b0;
        alu_rob_id    = 5'd0;
        alu_result    = 32'd0;
        alu_target_pc = 32'd0;
        alu_jump_flag = 1'b0;
        ls_valid      = 1'b0;
        ls_rob_id     = 5'd0;
        ls_result     = 32'd0;
    endtask

    task automatic set_alu(input logic [4:0] t, input logic [31:0] r);
        alu_valid     = 1'b1;
        alu_rob_id    = t;
        alu_result    = r;
        alu_target_pc = {r[29:0], 2'b00};
        alu_jump_flag = r[0];
    endtask

    task automatic set_ls(input logic [4:0] t, input logic [31:0] r);
        ls_valid  = 1'b1;
        ls_rob_id = t;
        ls_result = r;
    endtask

    initial begin
        rst           = 1'b1;
        rdy           = 1'b1;
        rollback_flag = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single ALU entry with explicit fields.
        alu_valid     = 1'b1;
        alu_rob_id    = 5'd3;
        alu_result    = 32'h11;
        alu_target_pc = 32'h40;
        alu_jump_flag = 1'b1;
        tick();
        idle_inputs();
        repeat (4) tick();

        // Interleaved sources: 1, 5, 2, 6.
        set_alu(5'd1, 32'hA1);
        set_ls(5'd5, 32'hB5);
        tick();
        set_alu(5'd2, 32'hA2);
        set_ls(5'd6, 32'hB6);
        tick();
        idle_inputs();
        repeat (6) tick();

        // Fill both queues, then freeze with a third ALU entry pending.
        set_alu(5'd7, 32'hC7);
        set_ls(5'd9, 32'hD9);
        tick();
        set_alu(5'd8, 32'hC8);
        set_ls(5'd10, 32'hDA);
        tick();
        set_alu(5'd11, 32'hCB);
        set_ls(5'd12, 32'hDC);
        tick();
        rdy = 1'b0;
        set_alu(5'd13, 32'hCD);
        repeat (3) tick();
        rdy = 1'b1;
        repeat (2) tick();
        idle_inputs();
        repeat (8) tick();

        // Rollback with queues partially full and ls_valid asserted.
        set_alu(5'd14, 32'hE1);
        set_ls(5'd15, 32'hE2);
        tick();
        set_alu(5'd16, 32'hE3);
        set_ls(5'd17, 32'hE4);
        tick();
        idle_inputs();
        set_ls(5'd18, 32'hE5);
        rollback_flag = 1'b1;
        tick();
        rollback_flag = 1'b0;
        idle_inputs();
        repeat (4) tick();

        // Tag 0 is accepted but never broadcast.
        set_alu(5'd0, 32'hF0);
        tick();
        idle_inputs();
        repeat (3) tick();

        // rdy low for 3 cycles mid-stream, then reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            set_alu(5'(20 + i), 32'h100 + i);
            set_ls(5'(24 + i), 32'h200 + i);
            tick();
        end
        rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        idle_inputs();
        tick();
        set_alu(5'd28, 32'h300);
        set_ls(5'd29, 32'h301);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rdy           = ($urandom_range(0, 99) < 85);
            rollback_flag = ($urandom_range(0, 99) < 3);
            rst           = ($urandom_range(0, 199) == 0);
            alu_valid     = ($urandom_range(0, 99) < 60);
            alu_rob_id    = 5'($urandom_range(0, 31));
            alu_result    = $urandom;
            alu_target_pc = $urandom;
            alu_jump_flag = 1'($urandom_range(0, 1));
            ls_valid      = ($urandom_range(0, 99) < 60);
            ls_rob_id     = 5'($urandom_range(0, 31));
            ls_result     = $urandom;
            tick();
        end

        rst           = 1'b0;
        rollback_flag = 1'b0;
        rdy           = 1'b1;
        idle_inputs();
        repeat (10) tick();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
